// File: rtl/fmul64_pkg.sv
// Shared constants, rounding-mode encoding and result types for the F64 multiplier back end.
// Both the normalise and the round/pack paths import this package.
package fmul64_pkg;

    localparam int unsigned F64_EXP_W  = 11;
    localparam int unsigned F64_FRAC_W = 52;
    localparam int unsigned SIG_MUL_W  = 106;
    localparam logic [F64_EXP_W-1:0] F64_MAX_EXP = 11'd2047;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic                  sign;
        logic [F64_EXP_W-1:0]  exp;
        logic [F64_FRAC_W-1:0] frac;
    } f64_t;

    typedef struct packed {
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Round-up decision from the kept LSB, guard and sticky bits.
    function automatic logic round_inc(input rm_e rm, input logic sign,
                                       input logic l, input logic g, input logic s);
        logic inc;
        case (rm)
            RM_RNE:  inc = g & (l | s);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (g | s);
            RM_RUP:  inc = ~sign & (g | s);
            RM_RMM:  inc = g;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fmul64_lsh_lzc.sv
// 105-bit leading-zero counter for the multiplier normalise stage.
// All-zero input yields 105.
module fmul64_lsh_lzc (
    input  logic [104:0] in_bits,
    output logic [6:0]   lzc
);

    logic [127:0] win;

    // Low padding with ones caps the count at 105; each level halves the search window.
    always_comb begin
        win = {in_bits, 23'h7F_FFFF};
        lzc = '0;
        for (int unsigned k = 7; k > 0; k--) begin
            if ((win >> (128 - (1 << (k - 1)))) == '0) begin
                lzc = lzc | 7'(1 << (k - 1));
                win = win << (1 << (k - 1));
            end
        end
    end

endmodule

// File: rtl/fmul64_lsh_round_pipe.sv
// F64 multiplier left-normalise, round and pack path; two-stage valid/ready pipeline.
// Define FMUL64_LSH_UF_AFTER_ROUND_EN for after-rounding tininess detection.
module fmul64_lsh_round_pipe
    import fmul64_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 sign_i,
    input  logic [12:0]          exp_i,
    input  logic [SIG_MUL_W-1:0] sig_mul_i,
    input  logic [2:0]           rm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [63:0]          res_o,
    output logic [2:0]           fflags_o
);

    localparam int unsigned SH_W = SIG_MUL_W - 1;

    logic                 s1_vld, s2_vld, s1_adv, s2_adv;
    logic                 s1_sign;
    rm_e                  s1_rm;
    logic [SH_W-1:0]      s1_sig;
    logic [6:0]           s1_lsh;
    logic [F64_EXP_W-1:0] s1_exp;

    logic [6:0]           lzc;
    logic [12:0]          exp_m1;
    logic [6:0]           lsh_num;
    logic                 sig_msb_unused;

    fmul64_lsh_lzc u_lzc (
        .in_bits (sig_mul_i[SH_W-1:0]),
        .lzc     (lzc)
    );

    assign sig_msb_unused = sig_mul_i[SH_W];
    assign exp_m1  = exp_i - 13'd1;
    // Clamp the shift so the biased exponent never drops below 1.
    assign lsh_num = ({6'd0, lzc} < exp_m1) ? lzc : exp_m1[6:0];

    assign s2_adv      = !s2_vld || out_ready_i;
    assign s1_adv      = s2_adv || !s1_vld;
    assign in_ready_o  = !s1_vld || s1_adv;
    assign out_valid_o = s2_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_rm   <= RM_RNE;
            s1_sig  <= '0;
            s1_lsh  <= '0;
            s1_exp  <= '0;
        end else if (flush_i) begin
            s1_vld  <= 1'b0;
        end else if (s1_adv) begin
            s1_vld <= in_valid_i;
            if (in_valid_i) begin
                s1_sign <= sign_i;
                s1_rm   <= rm_e'(rm_i);
                s1_sig  <= sig_mul_i[SH_W-1:0];
                s1_lsh  <= lsh_num;
                s1_exp  <= 11'(exp_i - {6'd0, lsh_num});
            end
        end
    end

    logic [SH_W-1:0]         sh;
    logic                    l_bit, g_bit, s_bit, inc, nx, of, uf, ovf_inf;
    logic [F64_FRAC_W+1:0]   sum;
    logic [F64_EXP_W-1:0]    exp_rnd;
    f64_t                    res_d;
    fflags_t                 flags_d;

    assign sh    = s1_sig << s1_lsh;
    assign l_bit = sh[52];
    assign g_bit = sh[51];
    assign s_bit = |sh[50:0];
    assign inc   = round_inc(s1_rm, s1_sign, l_bit, g_bit, s_bit);
    assign sum   = {1'b0, sh[104:52]} + {{(F64_FRAC_W+1){1'b0}}, inc};
    // A carry out of a denormal lands on the hidden-bit position and promotes it to exponent 1.
    assign exp_rnd = sh[104] ? (s1_exp + {10'd0, sum[53]}) : {10'd0, sum[52]};
    assign nx = g_bit | s_bit;
    assign of = (exp_rnd == F64_MAX_EXP);

`ifdef FMUL64_LSH_UF_AFTER_ROUND_EN
    logic rnd_up_uf;
    assign rnd_up_uf = round_inc(s1_rm, s1_sign, sh[51], sh[50], |sh[49:0]);
    assign uf = nx && !sh[104] && !((&sh[103:52]) && rnd_up_uf);
`else
    assign uf = nx && !sh[104];
`endif

    always_comb begin
        case (s1_rm)
            RM_RNE, RM_RMM: ovf_inf = 1'b1;
            RM_RUP:         ovf_inf = !s1_sign;
            RM_RDN:         ovf_inf = s1_sign;
            default:        ovf_inf = 1'b0;
        endcase
    end

    always_comb begin
        res_d.sign = s1_sign;
        res_d.exp  = exp_rnd;
        res_d.frac = sum[F64_FRAC_W-1:0];
        if (of) begin
            if (ovf_inf) begin
                res_d.frac = '0;
            end else begin
                res_d.exp  = F64_MAX_EXP - 11'd1;
                res_d.frac = '1;
            end
        end
        flags_d.of = of;
        flags_d.uf = uf;
        flags_d.nx = nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            res_o    <= '0;
            fflags_o <= '0;
        end else if (flush_i) begin
            s2_vld   <= 1'b0;
        end else if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                res_o    <= res_d;
                fflags_o <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fmul64_lsh_round_pipe.sv
// Self-checking bench for fmul64_lsh_round_pipe: directed vector table, pipeline corner
// sequences and randomized traffic checked against a value-level rounding model.
module tb_fmul64_lsh_round_pipe;

    logic         clk, rst_n, flush, in_valid, in_ready, sign;
    logic [12:0]  exp;
    logic [105:0] sig;
    logic [2:0]   rm;
    logic         out_valid, out_ready;
    logic [63:0]  res;
    logic [2:0]   fflags;

    fmul64_lsh_round_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .sign_i      (sign),
        .exp_i       (exp),
        .sig_mul_i   (sig),
        .rm_i        (rm),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .fflags_o    (fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sg;
        logic [12:0]  ex;
        logic [105:0] sm;
        logic [2:0]   rm;
        logic [63:0]  res;
        logic [2:0]   fl;
    } vec_t;

    vec_t        vecs[13];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_pop = -1;
    logic [66:0] sb[$];
    logic        prev_hold = 1'b0;
    logic [66:0] held = '0;

    task automatic check(input string name, input logic [66:0] got, input logic [66:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Reference: exact value sig * 2^(exp-1127), rounded to the F64 grid by integer arithmetic.
    function automatic logic [66:0] ref_model(input logic sg, input logic [12:0] ex13,
                                              input logic [105:0] sm, input logic [2:0] r);
        logic [127:0] s, q, rem, half;
        int           p, ex, u, e_res;
        logic         up, nx, tiny, of, inf;
        logic [63:0]  rv;
        s = {22'd0, sm};
        p = -1;
        for (int i = 0; i < 106; i++) if (s[i]) p = i;
        if (p < 0) return {3'b000, sg, 63'd0};
        ex   = int'(ex13);
        u    = (p - 52 > 53 - ex) ? p - 52 : 53 - ex;
        tiny = (ex - (104 - p)) < 1;
        if (u <= 0) begin
            q = s << (-u); rem = '0; half = '0;
        end else begin
            q = s >> u;
            rem  = s & ((128'd1 << u) - 128'd1);
            half = 128'd1 << (u - 1);
        end
        nx = (rem != 0);
        case (r)
            3'd0:    up = nx && ((rem > half) || (rem == half && q[0]));
            3'd2:    up = sg && nx;
            3'd3:    up = !sg && nx;
            3'd4:    up = nx && (rem >= half);
            default: up = 1'b0;
        endcase
        q = q + {127'd0, up};
        if (q >= (128'd1 << 52)) begin
            e_res = ex + u - 52;
            if (q >= (128'd1 << 53)) begin
                q = q >> 1;
                e_res++;
            end
        end else begin
            e_res = 0;
        end
        of = (e_res >= 2047);
        if (of) begin
            inf = (r == 3'd0) || (r == 3'd4) || (r == 3'd3 && !sg) || (r == 3'd2 && sg);
            rv  = inf ? {sg, 11'h7FF, 52'd0} : {sg, 11'h7FE, {52{1'b1}}};
            nx  = 1'b1;
        end else begin
            rv = {sg, e_res[10:0], q[51:0]};
        end
        return {of, nx && tiny, nx, rv};
    endfunction

    task automatic step(input logic iv, input logic sg, input logic [12:0] ex, input logic [105:0] sm,
                        input logic [2:0] r, input logic orr, input logic fl,
                        input logic [66:0] expv, output logic acc);
        logic [66:0] got;
        @(negedge clk);
        in_valid = iv; sign = sg; exp = ex; sig = sm; rm = r; out_ready = orr; flush = fl;
        #1;
        got = {fflags, res};
        if (prev_hold) begin
            check("hold_valid", {66'd0, out_valid}, 67'd1);
            check("hold_data", got, held);
        end
        acc = iv && in_ready && !fl;
        if (out_valid && orr && !fl) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got %h want none", got);
            end else begin
                check("result", got, sb.pop_front());
            end
            last_pop = cyc;
        end
        if (fl) sb.delete();
        else if (acc) sb.push_back(expv);
        prev_hold = out_valid && !orr && !fl;
        held = got;
        cyc++;
    endtask

    task automatic idle(input logic orr);
        logic a;
        step(1'b0, 1'b0, 13'd0, 106'd0, 3'd0, orr, 1'b0, 67'd0, a);
    endtask

    task automatic gen_op(output logic sg, output logic [12:0] ex, output logic [105:0] sm,
                          output logic [2:0] r);
        logic [127:0] rnd, mask;
        int           p, sel;
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        p = ($urandom_range(0, 1) == 0) ? int'($urandom_range(98, 104)) : int'($urandom_range(0, 104));
        mask = (128'd1 << p) - 128'd1;
        if ($urandom_range(0, 7) == 0) rnd = '1;
        sm = 106'((rnd & mask) | (128'd1 << p));
        if ($urandom_range(0, 31) == 0) sm = '0;
        sel = int'($urandom_range(0, 3));
        ex = (sel == 0) ? 13'($urandom_range(1, 60)) :
             (sel == 1) ? 13'($urandom_range(2000, 2046)) : 13'($urandom_range(1, 2046));
        r  = 3'($urandom_range(0, 4));
        sg = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic         acc, pend;
        int           acc_cyc, k;
        logic         o_sg[5];
        logic [12:0]  o_ex[5];
        logic [105:0] o_sm[5];
        logic [2:0]   o_rm[5];
        logic [105:0] one104, bit100, tie, allones, belowones;

        one104    = 106'd1 << 104;
        bit100    = 106'd1 << 100;
        tie       = one104 | (106'd1 << 51);
        allones   = {1'b0, {105{1'b1}}};
        belowones = {2'b00, {104{1'b1}}};
        vecs[0]  = '{1'b0, 13'd1023, one104,    3'd0, 64'h3FF0000000000000, 3'b000};
        vecs[1]  = '{1'b0, 13'd1023, bit100,    3'd0, 64'h3FB0000000000000, 3'b000};
        vecs[2]  = '{1'b0, 13'd3,    bit100,    3'd0, 64'h0004000000000000, 3'b000};
        vecs[3]  = '{1'b0, 13'd1023, tie,       3'd0, 64'h3FF0000000000000, 3'b001};
        vecs[4]  = '{1'b0, 13'd1023, tie,       3'd3, 64'h3FF0000000000001, 3'b001};
        vecs[5]  = '{1'b0, 13'd2046, allones,   3'd0, 64'h7FF0000000000000, 3'b101};
        vecs[6]  = '{1'b0, 13'd2046, allones,   3'd1, 64'h7FEFFFFFFFFFFFFF, 3'b001};
        vecs[7]  = '{1'b1, 13'd2046, allones,   3'd2, 64'hFFF0000000000000, 3'b101};
        vecs[8]  = '{1'b0, 13'd2046, allones,   3'd2, 64'h7FEFFFFFFFFFFFFF, 3'b001};
        vecs[9]  = '{1'b1, 13'd100,  106'd0,    3'd2, 64'h8000000000000000, 3'b000};
        vecs[10] = '{1'b0, 13'd1,    106'd3,    3'd3, 64'h0000000000000001, 3'b011};
        vecs[11] = '{1'b0, 13'd1,    belowones, 3'd0, 64'h0010000000000000, 3'b011};
        vecs[12] = '{1'b0, 13'd1023, tie,       3'd4, 64'h3FF0000000000001, 3'b001};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; sign = 1'b0; exp = '0; sig = '0;
        rm = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {66'd0, out_valid}, 67'd0);
        check("rst_res", {3'd0, res}, 67'd0);
        check("rst_fflags", {64'd0, fflags}, 67'd0);
        check("rst_in_ready", {66'd0, in_ready}, 67'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(1'b1, vecs[i].sg, vecs[i].ex, vecs[i].sm, vecs[i].rm, 1'b1, 1'b0,
                 {vecs[i].fl, vecs[i].res}, acc);
            check("vec_accept", {66'd0, acc}, 67'd1);
            acc_cyc  = cyc - 1;
            last_pop = -1;
            for (int w = 0; w < 8 && sb.size() > 0; w++) idle(1'b1);
            check("vec_latency", 67'(last_pop - acc_cyc), 67'd2);
            sb.delete();
        end

        // Back-to-back ops under three cycles of backpressure.
        for (int i = 0; i < 5; i++) gen_op(o_sg[i], o_ex[i], o_sm[i], o_rm[i]);
        k = 0;
        for (int c = 0; c < 3; c++) begin
            step(k < 4, o_sg[k], o_ex[k], o_sm[k], o_rm[k], 1'b0, 1'b0,
                 ref_model(o_sg[k], o_ex[k], o_sm[k], o_rm[k]), acc);
            if (acc) k++;
        end
        check("bp_accepted", 67'(k), 67'd2);
        check("bp_in_ready", {66'd0, in_ready}, 67'd0);
        for (int c = 0; c < 20 && (k < 4 || sb.size() > 0); c++) begin
            step(k < 4, o_sg[k], o_ex[k], o_sm[k], o_rm[k], 1'b1, 1'b0,
                 ref_model(o_sg[k], o_ex[k], o_sm[k], o_rm[k]), acc);
            if (acc) k++;
        end
        check("bp_all_in", 67'(k), 67'd4);
        check("bp_drained", 67'(sb.size()), 67'd0);

        // Flush with both stages full and a new op presented.
        for (int i = 0; i < 3; i++) gen_op(o_sg[i], o_ex[i], o_sm[i], o_rm[i]);
        for (int i = 0; i < 2; i++)
            step(1'b1, o_sg[i], o_ex[i], o_sm[i], o_rm[i], 1'b0, 1'b0,
                 ref_model(o_sg[i], o_ex[i], o_sm[i], o_rm[i]), acc);
        step(1'b1, o_sg[2], o_ex[2], o_sm[2], o_rm[2], 1'b0, 1'b1, 67'd0, acc);
        for (int c = 0; c < 3; c++) begin
            idle(1'b1);
            check("flush_no_valid", {66'd0, out_valid}, 67'd0);
        end

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 2; i++) gen_op(o_sg[i], o_ex[i], o_sm[i], o_rm[i]);
        for (int i = 0; i < 3; i++)
            step(i < 2, o_sg[i], o_ex[i], o_sm[i], o_rm[i], 1'b0, 1'b0,
                 ref_model(o_sg[i], o_ex[i], o_sm[i], o_rm[i]), acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {66'd0, out_valid}, 67'd0);
        check("midrst_res", {3'd0, res}, 67'd0);
        check("midrst_fflags", {64'd0, fflags}, 67'd0);
        check("midrst_in_ready", {66'd0, in_ready}, 67'd1);
        sb.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with random valid/ready.
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                gen_op(o_sg[0], o_ex[0], o_sm[0], o_rm[0]);
                pend = 1'b1;
            end
            step($urandom_range(0, 3) != 0, o_sg[0], o_ex[0], o_sm[0], o_rm[0],
                 $urandom_range(0, 3) != 0, 1'b0,
                 ref_model(o_sg[0], o_ex[0], o_sm[0], o_rm[0]), acc);
            if (acc) pend = 1'b0;
        end
        for (int c = 0; c < 20 && sb.size() > 0; c++) idle(1'b1);
        check("rand_drained", 67'(sb.size()), 67'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
